// File: rtl/vx_lsu_mem_unit_if.sv
// vx_lsu_mem_unit_if
// Bundle of the request, memory-request, memory-response and load-response
// channels of the load/store memory unit.
//   slave  : view used by vx_lsu_mem_unit (consumes req/mem_rsp, drives mem_req/rsp)
//   master : view used by whatever drives the unit (core side plus memory model)
// Signals:
//   req_*      multi-lane request from the core, req_ready is the consume strobe
//   mem_req_*  per-lane requests to the banked data cache, per-lane ready
//   mem_rsp_*  response beats from the cache, tagged with the slot index
//   rsp_*      load responses back to the core
//   empty      no outstanding loads and no partially sent request
interface vx_lsu_mem_unit_if #(
  parameter int NUM_LANES  = 4,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int QUEUE_SIZE = 8,
  parameter int TAG_WIDTH  = 16
);
  localparam int QW = $clog2(QUEUE_SIZE);
  localparam int WW = WORD_SIZE * 8;

  logic                            req_valid;
  logic                            req_rw;
  logic                            req_fence;
  logic [NUM_LANES-1:0]            req_mask;
  logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_LANES*WORD_SIZE-1:0]  req_byteen;
  logic [NUM_LANES*WW-1:0]         req_data;
  logic [TAG_WIDTH-1:0]            req_tag;
  logic                            req_ready;

  logic [NUM_LANES-1:0]            mem_req_valid;
  logic [NUM_LANES-1:0]            mem_req_rw;
  logic [NUM_LANES*ADDR_WIDTH-1:0] mem_req_addr;
  logic [NUM_LANES*WORD_SIZE-1:0]  mem_req_byteen;
  logic [NUM_LANES*WW-1:0]         mem_req_data;
  logic [NUM_LANES*QW-1:0]         mem_req_tag;
  logic [NUM_LANES-1:0]            mem_req_ready;

  logic                            mem_rsp_valid;
  logic [NUM_LANES-1:0]            mem_rsp_mask;
  logic [NUM_LANES*WW-1:0]         mem_rsp_data;
  logic [QW-1:0]                   mem_rsp_tag;
  logic                            mem_rsp_ready;

  logic                            rsp_valid;
  logic [NUM_LANES-1:0]            rsp_mask;
  logic [NUM_LANES*WW-1:0]         rsp_data;
  logic [TAG_WIDTH-1:0]            rsp_tag;
  logic                            rsp_eop;
  logic                            rsp_ready;

  logic                            empty;

  modport slave (
    input  req_valid, req_rw, req_fence, req_mask, req_addr, req_byteen, req_data, req_tag,
    output req_ready,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_mask, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready,
    output rsp_valid, rsp_mask, rsp_data, rsp_tag, rsp_eop,
    input  rsp_ready,
    output empty
  );

  modport master (
    output req_valid, req_rw, req_fence, req_mask, req_addr, req_byteen, req_data, req_tag,
    input  req_ready,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_mask, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready,
    input  rsp_valid, rsp_mask, rsp_data, rsp_tag, rsp_eop,
    output rsp_ready,
    input  empty
  );
endinterface

// File: rtl/vx_lsu_mem_unit.sv
// vx_lsu_mem_unit
// Load/store memory stage: splits a multi-lane request into per-lane cache
// requests with partial-acceptance tracking, keeps outstanding loads in a
// QUEUE_SIZE-entry slot table and returns load data either per beat
// (RSP_GATHER=0) or gathered into a single full-mask response (RSP_GATHER=1).
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    vx_lsu_mem_unit_if.slave (request, cache request/response, load response, empty)
module vx_lsu_mem_unit #(
  parameter int NUM_LANES  = 4,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int QUEUE_SIZE = 8,
  parameter int TAG_WIDTH  = 16,
  parameter int RSP_GATHER = 1
) (
  input logic              clk,
  input logic              reset,
  vx_lsu_mem_unit_if.slave bus
);
  localparam int QW = $clog2(QUEUE_SIZE);
  localparam int WW = WORD_SIZE * 8;

  typedef logic [NUM_LANES-1:0] lmask_t;
  typedef logic [WW-1:0]        word_t;

  // request-side state
  lmask_t        sent_q, sent_d;
  logic [QW-1:0] alloc_idx_q, alloc_idx_d;

  // slot table
  logic [QUEUE_SIZE-1:0] slot_valid_q, slot_valid_d;
  logic [TAG_WIDTH-1:0]  slot_tag_q  [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  slot_tag_d  [QUEUE_SIZE];
  lmask_t                slot_rem_q  [QUEUE_SIZE];
  lmask_t                slot_rem_d  [QUEUE_SIZE];
  lmask_t                slot_mask_q [QUEUE_SIZE];
  lmask_t                slot_mask_d [QUEUE_SIZE];
  word_t                 slot_buf_q  [QUEUE_SIZE][NUM_LANES];
  word_t                 slot_buf_d  [QUEUE_SIZE][NUM_LANES];

  // output stage
  logic                    rsp_valid_q, rsp_valid_d;
  lmask_t                  rsp_mask_q, rsp_mask_d;
  logic [NUM_LANES*WW-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]    rsp_tag_q, rsp_tag_d;
  logic                    rsp_eop_q, rsp_eop_d;

  logic          free_found;
  logic [QW-1:0] free_idx;
  logic          start, full, no_slots, dep_ok, lane_en, done, zero_mask, alloc;
  logic [QW-1:0] cur_idx;
  lmask_t        lane_fire;
  logic          stall, beat_fire, last;
  lmask_t        rem_next;
  word_t         merged [NUM_LANES];

  // lowest free slot index
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = QUEUE_SIZE - 1; s >= 0; s--) begin
      if (!slot_valid_q[s]) begin
        free_found = 1'b1;
        free_idx   = QW'(s);
      end
    end
  end

  // request path
  always_comb begin
    start     = (sent_q == '0);
    full      = ~free_found;
    no_slots  = ~|slot_valid_q;
    // only a fresh load needs a free slot; a load already mid-send owns one
    dep_ok    = bus.req_rw | ~full | ~start;
    lane_en   = bus.req_valid & ~bus.req_fence & dep_ok & ~reset;
    bus.mem_req_valid = {NUM_LANES{lane_en}} & bus.req_mask & ~sent_q;
    lane_fire = bus.mem_req_valid & bus.mem_req_ready;
    done      = (&(bus.mem_req_ready | sent_q | ~bus.req_mask)) & dep_ok;
    zero_mask = (bus.req_mask == '0);
    if (bus.req_fence) bus.req_ready = ~reset & bus.req_valid & no_slots;
    else               bus.req_ready = ~reset & bus.req_valid & (zero_mask | done);
    alloc     = bus.req_valid & ~bus.req_fence & ~bus.req_rw & start & (|lane_fire);
    cur_idx   = start ? free_idx : alloc_idx_q;

    bus.mem_req_rw     = {NUM_LANES{bus.req_rw}};
    bus.mem_req_addr   = bus.req_addr;
    bus.mem_req_byteen = bus.req_byteen;
    bus.mem_req_data   = bus.req_data;
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.mem_req_tag[l*QW +: QW] = bus.req_rw ? '0 : cur_idx;
    end

    sent_d      = bus.req_ready ? '0 : (sent_q | lane_fire);
    alloc_idx_d = alloc ? free_idx : alloc_idx_q;
  end

  // response path
  always_comb begin
    stall             = rsp_valid_q & ~bus.rsp_ready;
    bus.mem_rsp_ready = ~stall;
    beat_fire         = bus.mem_rsp_valid & ~stall;
    rem_next          = slot_rem_q[bus.mem_rsp_tag] & ~bus.mem_rsp_mask;
    last              = (rem_next == '0);
    for (int l = 0; l < NUM_LANES; l++) begin
      merged[l] = bus.mem_rsp_mask[l] ? bus.mem_rsp_data[l*WW +: WW]
                                      : slot_buf_q[bus.mem_rsp_tag][l];
    end
  end

  // slot table update; alloc and free never hit the same slot in one cycle
  // because allocation only picks slots that are currently free
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_tag_d   = slot_tag_q;
    slot_rem_d   = slot_rem_q;
    slot_mask_d  = slot_mask_q;
    slot_buf_d   = slot_buf_q;
    if (alloc) begin
      slot_valid_d[free_idx] = 1'b1;
      slot_tag_d[free_idx]   = bus.req_tag;
      slot_rem_d[free_idx]   = bus.req_mask;
      slot_mask_d[free_idx]  = bus.req_mask;
    end
    if (beat_fire) begin
      slot_rem_d[bus.mem_rsp_tag] = rem_next;
      if (RSP_GATHER != 0) slot_buf_d[bus.mem_rsp_tag] = merged;
      if (last) slot_valid_d[bus.mem_rsp_tag] = 1'b0;
    end
  end

  // output register
  always_comb begin
    rsp_valid_d = stall ? rsp_valid_q : 1'b0;
    rsp_mask_d  = rsp_mask_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_eop_d   = rsp_eop_q;
    if (beat_fire) begin
      if (RSP_GATHER == 0) begin
        rsp_valid_d = 1'b1;
        rsp_mask_d  = bus.mem_rsp_mask;
        rsp_data_d  = bus.mem_rsp_data;
        rsp_tag_d   = slot_tag_q[bus.mem_rsp_tag];
        rsp_eop_d   = last;
      end else if (last) begin
        rsp_valid_d = 1'b1;
        rsp_mask_d  = slot_mask_q[bus.mem_rsp_tag];
        for (int l = 0; l < NUM_LANES; l++) rsp_data_d[l*WW +: WW] = merged[l];
        rsp_tag_d   = slot_tag_q[bus.mem_rsp_tag];
        rsp_eop_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_q       <= '0;
      alloc_idx_q  <= '0;
      slot_valid_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_mask_q   <= '0;
      rsp_data_q   <= '0;
      rsp_tag_q    <= '0;
      rsp_eop_q    <= 1'b0;
    end else begin
      sent_q       <= sent_d;
      alloc_idx_q  <= alloc_idx_d;
      slot_valid_q <= slot_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_mask_q   <= rsp_mask_d;
      rsp_data_q   <= rsp_data_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_eop_q    <= rsp_eop_d;
    end
  end

  // slot payload is only meaningful while the slot is valid, so no reset
  always_ff @(posedge clk) begin
    slot_tag_q  <= slot_tag_d;
    slot_rem_q  <= slot_rem_d;
    slot_mask_q <= slot_mask_d;
    slot_buf_q  <= slot_buf_d;
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_mask  = rsp_mask_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_eop   = rsp_eop_q;
  assign bus.empty     = no_slots & start;

  // a beat must target a live slot and only lanes still awaited
  a_rsp_lanes_pending: assert property (@(posedge clk) disable iff (reset)
    beat_fire |-> (slot_valid_q[bus.mem_rsp_tag] &&
                   ((slot_rem_q[bus.mem_rsp_tag] & bus.mem_rsp_mask) == bus.mem_rsp_mask)));

endmodule

// File: tb/tb_vx_lsu_mem_unit.sv
module tb_vx_lsu_mem_unit;
  localparam int NL = 4;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int QS = 8;
  localparam int TW = 16;
  localparam int QW = 3;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              req_valid, req_rw, req_fence;
  logic [NL-1:0]     req_mask;
  logic [NL*AW-1:0]  req_addr;
  logic [NL*WS-1:0]  req_byteen;
  logic [NL*WW-1:0]  req_data;
  logic [TW-1:0]     req_tag;
  logic [NL-1:0]     mem_req_ready;
  logic              mem_rsp_valid;
  logic [NL-1:0]     mem_rsp_mask;
  logic [NL*WW-1:0]  mem_rsp_data;
  logic [QW-1:0]     mem_rsp_tag;
  logic              rsp_ready;

  vx_lsu_mem_unit_if #(.NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .QUEUE_SIZE(QS), .TAG_WIDTH(TW)) bus_g();
  vx_lsu_mem_unit_if #(.NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .QUEUE_SIZE(QS), .TAG_WIDTH(TW)) bus_s();

  assign bus_g.req_valid     = req_valid;
  assign bus_g.req_rw        = req_rw;
  assign bus_g.req_fence     = req_fence;
  assign bus_g.req_mask      = req_mask;
  assign bus_g.req_addr      = req_addr;
  assign bus_g.req_byteen    = req_byteen;
  assign bus_g.req_data      = req_data;
  assign bus_g.req_tag       = req_tag;
  assign bus_g.mem_req_ready = mem_req_ready;
  assign bus_g.mem_rsp_valid = mem_rsp_valid;
  assign bus_g.mem_rsp_mask  = mem_rsp_mask;
  assign bus_g.mem_rsp_data  = mem_rsp_data;
  assign bus_g.mem_rsp_tag   = mem_rsp_tag;
  assign bus_g.rsp_ready     = rsp_ready;

  assign bus_s.req_valid     = req_valid;
  assign bus_s.req_rw        = req_rw;
  assign bus_s.req_fence     = req_fence;
  assign bus_s.req_mask      = req_mask;
  assign bus_s.req_addr      = req_addr;
  assign bus_s.req_byteen    = req_byteen;
  assign bus_s.req_data      = req_data;
  assign bus_s.req_tag       = req_tag;
  assign bus_s.mem_req_ready = mem_req_ready;
  assign bus_s.mem_rsp_valid = mem_rsp_valid;
  assign bus_s.mem_rsp_mask  = mem_rsp_mask;
  assign bus_s.mem_rsp_data  = mem_rsp_data;
  assign bus_s.mem_rsp_tag   = mem_rsp_tag;
  assign bus_s.rsp_ready     = rsp_ready;

  vx_lsu_mem_unit #(.NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .QUEUE_SIZE(QS),
                    .TAG_WIDTH(TW), .RSP_GATHER(1)) dut_g (.clk(clk), .reset(reset), .bus(bus_g));
  vx_lsu_mem_unit #(.NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .QUEUE_SIZE(QS),
                    .TAG_WIDTH(TW), .RSP_GATHER(0)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*WW +: WW] = b + 32'(i);
    return r;
  endfunction

  function automatic logic [11:0] rep_tag(input int t);
    logic [11:0] r;
    for (int i = 0; i < NL; i++) r[i*QW +: QW] = QW'(t);
    return r;
  endfunction

  task automatic clear_inputs();
    req_valid = 1'b0; req_rw = 1'b0; req_fence = 1'b0; req_mask = '0;
    req_addr = {4{30'h1234}}; req_byteen = '1; req_data = lanes(32'hD000); req_tag = '0;
    mem_req_ready = '0; mem_rsp_valid = 1'b0; mem_rsp_mask = '0; mem_rsp_data = '0;
    mem_rsp_tag = '0; rsp_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [3:0] m, input logic [3:0] rdy, input logic [15:0] t);
    req_valid = 1'b1; req_rw = 1'b0; req_fence = 1'b0; req_mask = m;
    mem_req_ready = rdy; req_tag = t;
  endtask

  task automatic beat(input logic [3:0] m, input logic [127:0] d, input int t);
    mem_rsp_valid = 1'b1; mem_rsp_mask = m; mem_rsp_data = d; mem_rsp_tag = QW'(t);
  endtask

  typedef struct {
    string      name;
    logic       valid;
    logic       rw;
    logic       fence;
    logic [3:0] mask;
    logic [3:0] rdy;
    logic       exp_ready;
    logic [3:0] exp_mvalid;
    logic       exp_empty_after;
  } vec_t;

  vec_t vecs[9];
  logic [127:0] exp_d;

  initial begin
    vecs[0] = '{"idle",       1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1};
    vecs[1] = '{"ld_all",     1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0};
    vecs[2] = '{"ld_part",    1'b1, 1'b0, 1'b0, 4'b1111, 4'b0011, 1'b0, 4'b1111, 1'b0};
    vecs[3] = '{"st_all",     1'b1, 1'b1, 1'b0, 4'b1011, 4'b1111, 1'b1, 4'b1011, 1'b1};
    vecs[4] = '{"st_part",    1'b1, 1'b1, 1'b0, 4'b0110, 4'b0010, 1'b0, 4'b0110, 1'b0};
    vecs[5] = '{"ld_zero",    1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};
    vecs[6] = '{"fence_idle", 1'b1, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1};
    vecs[7] = '{"ld_nordy",   1'b1, 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0101, 1'b1};
    vecs[8] = '{"st_zero",    1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1};

    // reset state
    do_reset();
    chk("rst_req_ready", bus_g.req_ready, 0);
    chk("rst_mem_req_valid", bus_g.mem_req_valid, 0);
    chk("rst_rsp_valid", bus_g.rsp_valid, 0);
    chk("rst_rsp_eop", bus_g.rsp_eop, 0);
    chk("rst_mem_rsp_ready", bus_g.mem_rsp_ready, 1);
    chk("rst_empty", bus_g.empty, 1);

    // single-cycle request vectors, each from a fresh reset
    for (int v = 0; v < 9; v++) begin
      do_reset();
      req_valid = vecs[v].valid; req_rw = vecs[v].rw; req_fence = vecs[v].fence;
      req_mask = vecs[v].mask; mem_req_ready = vecs[v].rdy; req_tag = 16'h00A0;
      #1;
      chk({vecs[v].name, "_req_ready"}, bus_g.req_ready, vecs[v].exp_ready);
      chk({vecs[v].name, "_mem_req_valid"}, bus_g.mem_req_valid, vecs[v].exp_mvalid);
      chk({vecs[v].name, "_mem_req_tag"}, bus_g.mem_req_tag, 0);
      tick();
      clear_inputs();
      #1;
      chk({vecs[v].name, "_empty_after"}, bus_g.empty, vecs[v].exp_empty_after);
    end

    // full-mask load, single beat
    do_reset();
    load(4'b1111, 4'b1111, 16'hAAAA);
    #1;
    chk("basic_req_ready", bus_g.req_ready, 1);
    chk("basic_mem_req_valid", bus_g.mem_req_valid, 4'b1111);
    tick();
    clear_inputs();
    #1;
    chk("basic_empty_busy", bus_g.empty, 0);
    beat(4'b1111, lanes(32'h100), 0);
    #1;
    chk("basic_mem_rsp_ready", bus_g.mem_rsp_ready, 1);
    tick();
    clear_inputs();
    #1;
    chk("basic_rsp_valid", bus_g.rsp_valid, 1);
    chk("basic_rsp_mask", bus_g.rsp_mask, 4'b1111);
    chk("basic_rsp_data", bus_g.rsp_data, lanes(32'h100));
    chk("basic_rsp_eop", bus_g.rsp_eop, 1);
    chk("basic_rsp_tag", bus_g.rsp_tag, 16'hAAAA);
    chk("basic_empty_done", bus_g.empty, 1);
    tick();
    chk("basic_rsp_clear", bus_g.rsp_valid, 0);

    // partial acceptance
    do_reset();
    load(4'b1111, 4'b0011, 16'h0042);
    #1;
    chk("part0_mem_req_valid", bus_g.mem_req_valid, 4'b1111);
    chk("part0_req_ready", bus_g.req_ready, 0);
    tick();
    mem_req_ready = 4'b1100;
    #1;
    chk("part1_mem_req_valid", bus_g.mem_req_valid, 4'b1100);
    chk("part1_mem_req_tag", bus_g.mem_req_tag, rep_tag(0));
    chk("part1_req_ready", bus_g.req_ready, 1);
    tick();
    clear_inputs();

    // split beats: gather vs scatter
    do_reset();
    load(4'b1111, 4'b1111, 16'h0055);
    tick();
    clear_inputs();
    beat(4'b0101, lanes(32'h200), 0);
    tick();
    clear_inputs();
    #1;
    chk("gath_b0_rsp_valid", bus_g.rsp_valid, 0);
    chk("scat_b0_rsp_valid", bus_s.rsp_valid, 1);
    chk("scat_b0_rsp_mask", bus_s.rsp_mask, 4'b0101);
    chk("scat_b0_rsp_data", bus_s.rsp_data, lanes(32'h200));
    chk("scat_b0_rsp_eop", bus_s.rsp_eop, 0);
    beat(4'b1010, lanes(32'h300), 0);
    tick();
    clear_inputs();
    #1;
    exp_d = lanes(32'h300);
    exp_d[31:0]  = 32'h200;
    exp_d[95:64] = 32'h202;
    chk("gath_rsp_valid", bus_g.rsp_valid, 1);
    chk("gath_rsp_mask", bus_g.rsp_mask, 4'b1111);
    chk("gath_rsp_data", bus_g.rsp_data, exp_d);
    chk("gath_rsp_eop", bus_g.rsp_eop, 1);
    chk("gath_rsp_tag", bus_g.rsp_tag, 16'h0055);
    chk("scat_b1_rsp_mask", bus_s.rsp_mask, 4'b1010);
    chk("scat_b1_rsp_eop", bus_s.rsp_eop, 1);
    chk("gath_empty", bus_g.empty, 1);
    tick();

    // queue full, slot 3 returned
    do_reset();
    for (int i = 0; i < QS; i++) begin
      load(4'b0001, 4'b0001, 16'h0020 + 16'(i));
      #1;
      chk($sformatf("fill%0d_tag", i), bus_g.mem_req_tag, rep_tag(i));
      chk($sformatf("fill%0d_ready", i), bus_g.req_ready, 1);
      tick();
    end
    load(4'b0001, 4'b0001, 16'h0099);
    #1;
    chk("full_mem_req_valid", bus_g.mem_req_valid, 0);
    chk("full_req_ready", bus_g.req_ready, 0);
    beat(4'b0001, lanes(32'h700), 3);
    #1;
    chk("full_still_held", bus_g.mem_req_valid, 0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("refill_mem_req_valid", bus_g.mem_req_valid, 4'b0001);
    chk("refill_tag", bus_g.mem_req_tag, rep_tag(3));
    chk("refill_req_ready", bus_g.req_ready, 1);
    chk("slot3_rsp_tag", bus_g.rsp_tag, 16'h0023);
    tick();
    clear_inputs();

    // fence behind two loads
    do_reset();
    load(4'b0001, 4'b0001, 16'h0030);
    tick();
    load(4'b0001, 4'b0001, 16'h0031);
    tick();
    clear_inputs();
    req_valid = 1'b1; req_fence = 1'b1; req_mask = 4'b1111; mem_req_ready = 4'b1111;
    #1;
    chk("fence_wait0", bus_g.req_ready, 0);
    chk("fence_no_traffic", bus_g.mem_req_valid, 0);
    beat(4'b0001, lanes(32'h0), 0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("fence_wait1", bus_g.req_ready, 0);
    beat(4'b0001, lanes(32'h0), 1);
    #1;
    chk("fence_wait2", bus_g.req_ready, 0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("fence_go", bus_g.req_ready, 1);
    tick();
    clear_inputs();

    // back-pressure on the output stage
    do_reset();
    load(4'b1111, 4'b1111, 16'h0010);
    tick();
    load(4'b1111, 4'b1111, 16'h0011);
    tick();
    clear_inputs();
    beat(4'b1111, lanes(32'h400), 0);
    tick();
    rsp_ready = 1'b0;
    beat(4'b1111, lanes(32'h500), 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_mem_rsp_ready", c), bus_g.mem_rsp_ready, 0);
      chk($sformatf("stall%0d_rsp_valid", c), bus_g.rsp_valid, 1);
      chk($sformatf("stall%0d_rsp_data", c), bus_g.rsp_data, lanes(32'h400));
      chk($sformatf("stall%0d_rsp_tag", c), bus_g.rsp_tag, 16'h0010);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("unstall_mem_rsp_ready", bus_g.mem_rsp_ready, 1);
    tick();
    clear_inputs();
    #1;
    chk("unstall_rsp_data", bus_g.rsp_data, lanes(32'h500));
    chk("unstall_rsp_tag", bus_g.rsp_tag, 16'h0011);

    // reset in the middle of a partial send
    do_reset();
    load(4'b1111, 4'b0011, 16'h0099);
    tick();
    reset = 1'b1;
    tick();
    chk("rmid_req_ready", bus_g.req_ready, 0);
    chk("rmid_mem_req_valid", bus_g.mem_req_valid, 0);
    chk("rmid_rsp_valid", bus_g.rsp_valid, 0);
    chk("rmid_mem_rsp_ready", bus_g.mem_rsp_ready, 1);
    chk("rmid_empty", bus_g.empty, 1);
    reset = 1'b0;
    mem_req_ready = 4'b1111;
    #1;
    chk("rmid_reissue_valid", bus_g.mem_req_valid, 4'b1111);
    chk("rmid_reissue_tag", bus_g.mem_req_tag, rep_tag(0));
    chk("rmid_reissue_ready", bus_g.req_ready, 1);
    tick();
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
